// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR low-pass filter and its downstream stages.
package fir_pkg;

  localparam int unsigned FIR_DATA_W  = 12;
  localparam int unsigned FIR_TAPS    = 64;
  // Input register, product register, sum register.
  localparam int unsigned FIR_LATENCY = 3;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small first-word-fall-through FIFO; the head is visible combinationally while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (fill_q == FILL_W'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = empty_o ? '0 : mem[rdPtr_q];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    fill_d  = fill_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    unique case ({doPush, doPop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      fill_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      fill_q  <= fill_d;
    end
  end

  // Storage needs no reset: fill gates what is visible at the head.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Discards FIR pipeline-fill samples after reset, keeps one sample in every DECIM,
// and buffers kept samples in a FWFT FIFO with a sticky overflow flag.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DATA_W,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = FIR_TAPS + FIR_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   sample_in,
  input  logic                       clear_ovf,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned WARM_W = $clog2(WARMUP + 1);
  localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);

  ctrl_state_e       state_q, state_d;
  logic [WARM_W-1:0] warmCnt_q, warmCnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              ovf_q, ovf_d;
  logic              push;
  logic              pop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [DATA_W-1:0] fifoData;

  // WARM counts off the pipeline-fill cycles; RUN requests a push on every phase-0 cycle.
  always_comb begin
    state_d   = state_q;
    warmCnt_d = warmCnt_q;
    phase_d   = phase_q;
    push      = 1'b0;
    unique case (state_q)
      WARM: begin
        warmCnt_d = warmCnt_q + 1'b1;
        if (warmCnt_q == WARM_LAST) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
      RUN: begin
        push    = (phase_q == '0);
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
      default: state_d = WARM;
    endcase
  end

  // A drop outranks a same-cycle clear so that no lost sample goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifoFull && !pop) ovf_d = 1'b1;
    else if (clear_ovf)           ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WARM;
      warmCnt_q <= '0;
      phase_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      warmCnt_q <= warmCnt_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifoEmpty;
  assign out_data  = fifoData;
  assign overflow  = ovf_q;

  sync_fifo_fwft #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (sample_in),
    .data_o (fifoData),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .fill_o (fill)
  );

endmodule
